instr_queue: RTL

Fetch-to-decode instruction queue for the RISC-V pipeline. Captures each instruction word and its `pcplus1` from the fetch stage, buffers up to `DEPTH` entries, and presents the oldest entry to decode together with predecoded register and opcode fields. On a taken branch it flushes all buffered entries. Its `out_enable` drives the fetch stage's `in_enable`, so backpressure stalls fetch.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/instr_queue_if.sv | 34 +++
 rtl/instr_predecode.sv | 24 ++
 rtl/instr_queue.sv | 90 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline types and opcode constants
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [ILEN-1:0] instruction;
    logic [XLEN-1:0] pcplus1;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch/decode handshake bundle for the instruction queue
interface instr_queue_if #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32
);
  logic                         in_valid;
  logic [INSTRUCTION_WIDTH-1:0] in_instruction_bits;
  logic [ADDRESS_WIDTH-1:0]     in_pcplus1;
  logic                         in_flush;
  logic                         out_enable;
  logic                         in_decode_ready;
  logic                         out_valid;
  logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits;
  logic [ADDRESS_WIDTH-1:0]     out_pc;
  logic [ADDRESS_WIDTH-1:0]     out_pcplus1;
  logic [6:0]                   out_opcode;
  logic [4:0]                   out_rd;
  logic [4:0]                   out_rs1;
  logic [4:0]                   out_rs2;
  logic                         out_is_ctrl;
  logic                         out_illegal;

  modport master (
    output in_valid, in_instruction_bits, in_pcplus1, in_flush, in_decode_ready,
    input  out_enable, out_valid, out_instruction_bits, out_pc, out_pcplus1,
           out_opcode, out_rd, out_rs1, out_rs2, out_is_ctrl, out_illegal
  );

  modport slave (
    input  in_valid, in_instruction_bits, in_pcplus1, in_flush, in_decode_ready,
    output out_enable, out_valid, out_instruction_bits, out_pc, out_pcplus1,
           out_opcode, out_rd, out_rs1, out_rs2, out_is_ctrl, out_illegal
  );
endinterface

// File: rtl/instr_predecode.sv
// rtl/instr_predecode.sv - combinational field extraction shared by queue and decode
module instr_predecode
  import riscv_pkg::*;
(
  input  logic [ILEN-1:0] instruction,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            is_ctrl,
  output logic            illegal
);
  logic unused_bits;

  assign opcode  = instruction[6:0];
  assign rd      = instruction[11:7];
  assign rs1     = instruction[19:15];
  assign rs2     = instruction[24:20];
  assign is_ctrl = (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  // Compressed encodings have low bits other than 2'b11 and are not supported.
  assign illegal = (instruction[1:0] != 2'b11);

  assign unused_bits = ^{instruction[31:25], instruction[14:12]};
endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - fetch-to-decode circular instruction buffer with predecode
module instr_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH             = 4,
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  instr_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  iq_entry_t     mem [DEPTH];

  logic push;
  logic pop;
  logic out_valid_i;
  logic out_enable_i;

  assign out_valid_i  = (count != '0);
  assign out_enable_i = (count != FULL_COUNT);
  assign push = bus.in_valid && out_enable_i && !bus.in_flush;
  assign pop  = out_valid_i && bus.in_decode_ready && !bus.in_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.in_flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= '{instruction: bus.in_instruction_bits, pcplus1: bus.in_pcplus1};
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  logic [INSTRUCTION_WIDTH-1:0] head_instruction;
  logic [ADDRESS_WIDTH-1:0]     head_pcplus1;
  logic [6:0]                   pd_opcode;
  logic [4:0]                   pd_rd;
  logic [4:0]                   pd_rs1;
  logic [4:0]                   pd_rs2;
  logic                         pd_is_ctrl;
  logic                         pd_illegal;

  assign head_instruction = mem[head_ptr].instruction;
  assign head_pcplus1     = mem[head_ptr].pcplus1;

  instr_predecode u_predecode (
    .instruction (head_instruction),
    .opcode      (pd_opcode),
    .rd          (pd_rd),
    .rs1         (pd_rs1),
    .rs2         (pd_rs2),
    .is_ctrl     (pd_is_ctrl),
    .illegal     (pd_illegal)
  );

  // Head-derived outputs read as zero whenever the queue is empty.
  assign bus.out_valid            = out_valid_i;
  assign bus.out_enable           = out_enable_i;
  assign bus.out_instruction_bits = out_valid_i ? head_instruction : '0;
  assign bus.out_pcplus1          = out_valid_i ? head_pcplus1 : '0;
  assign bus.out_pc               = out_valid_i ? (head_pcplus1 - ADDRESS_WIDTH'(4)) : '0;
  assign bus.out_opcode           = out_valid_i ? pd_opcode : '0;
  assign bus.out_rd               = out_valid_i ? pd_rd : '0;
  assign bus.out_rs1              = out_valid_i ? pd_rs1 : '0;
  assign bus.out_rs2              = out_valid_i ? pd_rs2 : '0;
  assign bus.out_is_ctrl          = out_valid_i && pd_is_ctrl;
  assign bus.out_illegal          = out_valid_i && pd_illegal;
endmodule
